rvv_alu_seq: RTL
================

# rvv_alu_seq

Sequencer and result collector placed directly around `rvv_alu`. It accepts one vector arithmetic or mask instruction from the decode stage, steps every `rvv_alu` lane through all elements and sub-lane chunks by driving `run`, `byte_i` and `in_reg_offset`, and merges the per-lane `vd`/`index` results into a VLEN-bit destination image. Tail elements at or beyond `vl` keep their old value. The finished image goes to register-file writeback through a valid/ready handshake.

## Interface
Parameters:
- `VLEN`, 128: vector register width in bits, a power of two, 64 to 65536.
- `LANE_WIDTH`, 3: log2 of the lane chunk width in bits, range 3 to 6. Must match the `rvv_alu` instances.
- `NB_LANES`, 2: number of `rvv_alu` instances, with `LANE_I` values 0 to NB_LANES-1. Power of two, at least 1.

Ports:
- `clk`  in  1  the block's only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  instruction request; sampled only in IDLE.
- `instr_mask`  in  1  1 for a mask-logical instruction.
- `vsew`  in  3  element width code; values 0 to 3 are legal.
- `vl`  in  17  active element count. For mask instructions it is a bit count.
- `vd_old`  in  VLEN  current destination register contents.
- `busy`  out  1  high in RUN and WB.
- `error`  out  1  one-cycle pulse when an illegal `vsew` is received.
- `alu_run`  out  1  to every lane's `run` input.
- `alu_vsew`  out  3  effective SEW driven to the lanes.
- `alu_byte_i`  out  17  element-group base driven to the lanes.
- `alu_in_reg_offset`  out  4  chunk index within the element.
- `alu_vd`  in  NB_LANES*64  concatenated lane `vd` outputs, lane 0 in the LSBs.
- `alu_index`  in  NB_LANES*17  concatenated lane `index` outputs.
- `wb_valid`  out  1  destination image ready.
- `wb_ready`  in  1  writeback accepts the image.
- `wb_data`  out  VLEN  merged destination image.

## Operation
States are IDLE, RUN and WB.

- **IDLE, on `start`:**
  - Latch the instruction: `ew` = `instr_mask ? LANE_WIDTH-3 : vsew`.
  - Element count `n`: for a mask instruction, `ceil(vl / 2^LANE_WIDTH)`; otherwise `vl`.
  - Chunk count `chunks` = `max(1, 2^(ew+3-LANE_WIDTH))`.
  - Load the buffer with `vd_old` and clear the offset and `byte_i` counters.
  - If `vsew > 3` and the instruction is not a mask instruction: pulse `error`, stay in IDLE, no writeback.
  - If `n == 0`: go to WB.
  - Otherwise go to RUN.
- **RUN, every cycle:**
  - `alu_run` = 1 and `alu_vsew` = `ew`.
  - For each lane i whose element `alu_byte_i + i < n`, write `w` bits of `alu_vd[i]` LSBs into the buffer at bit position `alu_index[i]` (low log2(VLEN) bits).
  - `w` = `min(2^LANE_WIDTH, 2^(ew+3))`.
  - Lanes with `alu_byte_i + i >= n` write nothing (tail undisturbed).
- **RUN, counter advance:**
  - `alu_in_reg_offset` increments each cycle.
  - At `chunks-1` it wraps to 0 and `alu_byte_i` advances by `NB_LANES`.
  - The cycle with the last chunk and `alu_byte_i + NB_LANES >= n` is the final RUN cycle. Its writes are committed and the state goes to WB.
- **WB:**
  - `wb_valid` = 1 and `wb_data` = buffer.
  - On `wb_valid && wb_ready`, go to IDLE.
- **Ignored inputs:** `start` in RUN or WB is ignored. `vl`, `vsew` and `vd_old` are not re-sampled outside the IDLE start cycle.
- **Same-cycle write collision:** two lanes never target the same bits in one cycle. If they do, the higher lane number wins.

## Timing
- **Reset values:** all outputs 0 (`busy`, `error`, `alu_run`, `alu_vsew`, `alu_byte_i`, `alu_in_reg_offset`, `wb_valid`, `wb_data`); state IDLE; buffer 0.
- **Reset mid-instruction:** reset asserted in any state aborts with no writeback.
- **Start to first lane cycle:** the `start` cycle is in IDLE; `alu_run` rises on the next edge.
- **RUN length:** exactly `ceil(n / NB_LANES) * chunks` cycles.
- **Writeback:** `wb_valid` rises on the edge after the final RUN cycle and holds, with `wb_data` stable, until `wb_ready`. With `n == 0`, `wb_valid` rises one edge after `start`.
- **Lane capture:** lane outputs are combinational in the RUN cycle and are registered into the buffer at that cycle's edge. The lane's internal carry and compare state relies on `alu_in_reg_offset` returning to 0 at every element start; this block guarantees it.
- **`error`:** high for exactly the cycle after the offending `start`.
- **Throughput:** back-to-back instructions are possible. `start` is accepted in the cycle after the WB handshake, so there is at least one idle cycle between instructions.

## Structure
- Shared package `rvv_pkg` holds:
  - the state enum (IDLE, RUN, WB);
  - the `op_type` constants VV=001, VX=010, VI=100;
  - the opcode encodings shared with the decoder and `rvv_alu`;
  - `chunks` and `w` computed as functions of `ew` and LANE_WIDTH.
- One sub-module, `rvv_lane_merge`: the masked `w`-bit insertion of one lane result into the VLEN buffer, instantiated NB_LANES times in a generate loop. The FSM and counters stay in the top module.

## Test plan
- **Tail undisturbed:** VLEN=128, LANE_WIDTH=3, NB_LANES=2, vadd, vsew=0, vl=5, `vd_old` all 0xAA. Expect 3 RUN cycles, bytes 0–4 equal to the sums, bytes 5–15 still 0xAA, `wb_valid` on the 4th edge after `start`.
- **Multi-chunk elements:** vsew=3, LANE_WIDTH=3, vl=2, NB_LANES=2, 0xFFFFFFFFFFFFFFFF+1. Expect 8 RUN cycles with offsets 0–7 in order, result 0 (carry chained), `alu_byte_i` constant at 0.
- **Empty and illegal instructions:**
  - vl=0: `wb_valid` one edge after `start`, `wb_data` equals `vd_old`, no `alu_run`.
  - vsew=4: `error` high for one cycle, no `wb_valid`.
- **Writeback backpressure:** `wb_ready` low 3 cycles in WB. `wb_data` stays stable and a `start` pulse is ignored. The state returns to IDLE the cycle after `wb_ready` goes high.
- **Reset and restart:** assert `reset` in the 2nd RUN cycle. All outputs are 0 immediately (asynchronous). A new `start` after release completes normally.
- **Mask instruction:** vmxor with vl=128, LANE_WIDTH=3, NB_LANES=2. Expect 8 RUN cycles with `alu_vsew`=0 and the full 128-bit XOR in `wb_data`.

Source files
------------

// File: rtl/rvv_pkg.sv
// Definitions shared by the decoder, rvv_alu and the lane sequencer:
// sequencer states, operand-type/opcode encodings and SEW-derived sizing helpers.
package rvv_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_WB} seq_state_e;

    localparam logic [2:0] OP_VV = 3'b001;
    localparam logic [2:0] OP_VX = 3'b010;
    localparam logic [2:0] OP_VI = 3'b100;

    localparam logic [5:0] ALU_ADD   = 6'b000000;
    localparam logic [5:0] ALU_SUB   = 6'b000010;
    localparam logic [5:0] ALU_AND   = 6'b001001;
    localparam logic [5:0] ALU_OR    = 6'b001010;
    localparam logic [5:0] ALU_XOR   = 6'b001011;
    localparam logic [5:0] MASK_AND  = 6'b011001;
    localparam logic [5:0] MASK_OR   = 6'b011010;
    localparam logic [5:0] MASK_XOR  = 6'b011011;

    // Chunks per element minus one; an element narrower than a lane chunk takes one.
    function automatic logic [3:0] chunks_m1(input logic [2:0] ew, input int lw);
        int sh;
        sh = int'(ew) + 3 - lw;
        if (sh <= 0) return 4'd0;
        return 4'((1 << sh) - 1);
    endfunction

    // log2 of the bits written per lane per cycle: min(LANE_WIDTH, ew+3).
    function automatic int lane_w_log(input logic [2:0] ew, input int lw);
        return (int'(ew) + 3 < lw) ? int'(ew) + 3 : lw;
    endfunction

    function automatic logic [63:0] w_mask(input logic [2:0] ew, input int lw);
        int wl;
        wl = lane_w_log(ew, lw);
        if (wl >= 6) return '1;
        return (64'd1 << (1 << wl)) - 64'd1;
    endfunction

endpackage

// File: rtl/rvv_alu_seq_if.sv
// Writeback handshake carrying the merged destination image to the register file.
interface rvv_alu_seq_if #(parameter int VLEN = 128);
    logic            wb_valid;
    logic            wb_ready;
    logic [VLEN-1:0] wb_data;

    modport master (output wb_valid, output wb_data, input wb_ready);
    modport slave  (input wb_valid, input wb_data, output wb_ready);
endinterface

// File: rtl/rvv_lane_merge.sv
// Inserts the low w bits of one lane result into the destination image at the
// lane-reported bit index; disabled lanes pass the image through untouched.
module rvv_lane_merge
    import rvv_pkg::*;
#(
    parameter int VLEN       = 128,
    parameter int LANE_WIDTH = 3
) (
    input  logic [VLEN-1:0] buf_i,
    input  logic            en,
    input  logic [2:0]      ew,
    input  logic [63:0]     vd,
    input  logic [16:0]     index,
    output logic [VLEN-1:0] buf_o
);
    localparam int PW = $clog2(VLEN);

    logic [VLEN-1:0] m_wide;
    logic [VLEN-1:0] d_wide;
    logic [PW-1:0]   pos;
    logic            unused_idx;

    assign pos        = index[PW-1:0];
    assign unused_idx = ^index[16:PW];

    always_comb begin
        m_wide        = '0;
        d_wide        = '0;
        m_wide[63:0]  = w_mask(ew, LANE_WIDTH);
        d_wide[63:0]  = vd & m_wide[63:0];
        buf_o         = buf_i;
        if (en) buf_o = (buf_i & ~(m_wide << pos)) | (d_wide << pos);
    end
endmodule

// File: rtl/rvv_alu_seq.sv
// Steps all rvv_alu lanes through elements and chunks of one instruction,
// merges lane results into a tail-undisturbed image and hands it to writeback.
module rvv_alu_seq
    import rvv_pkg::*;
#(
    parameter int VLEN       = 128,
    parameter int LANE_WIDTH = 3,
    parameter int NB_LANES   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     instr_mask,
    input  logic [2:0]               vsew,
    input  logic [16:0]              vl,
    input  logic [VLEN-1:0]          vd_old,
    output logic                     busy,
    output logic                     error,
    output logic                     alu_run,
    output logic [2:0]               alu_vsew,
    output logic [16:0]              alu_byte_i,
    output logic [3:0]               alu_in_reg_offset,
    input  logic [NB_LANES*64-1:0]   alu_vd,
    input  logic [NB_LANES*17-1:0]   alu_index,
    rvv_alu_seq_if.master            wb
);
    seq_state_e      state_q, state_d;
    logic [2:0]      ew_q, ew_d;
    logic [16:0]     n_q, n_d;
    logic [3:0]      cmax_q, cmax_d;
    logic [3:0]      off_q, off_d;
    logic [16:0]     bi_q, bi_d;
    logic [VLEN-1:0] buf_q, buf_d;
    logic            err_q, err_d;

    logic [NB_LANES:0][VLEN-1:0] chain;
    logic [17:0] vl_up;
    logic [2:0]  ew_new;
    logic [16:0] n_new;
    logic        last;

    assign chain[0] = buf_q;

    // Higher lanes sit later in the chain, so they win any overlapping write.
    for (genvar i = 0; i < NB_LANES; i++) begin : g_lane
        logic [17:0] elem;
        assign elem = {1'b0, bi_q} + 18'(i);
        rvv_lane_merge #(.VLEN(VLEN), .LANE_WIDTH(LANE_WIDTH)) u_merge (
            .buf_i (chain[i]),
            .en    (elem < {1'b0, n_q}),
            .ew    (ew_q),
            .vd    (alu_vd[i*64 +: 64]),
            .index (alu_index[i*17 +: 17]),
            .buf_o (chain[i+1])
        );
    end

    assign vl_up  = 18'(vl) + 18'((1 << LANE_WIDTH) - 1);
    assign ew_new = instr_mask ? 3'(LANE_WIDTH - 3) : vsew;
    assign n_new  = instr_mask ? 17'(vl_up >> LANE_WIDTH) : vl;
    assign last   = (off_q == cmax_q) && (({1'b0, bi_q} + 18'(NB_LANES)) >= {1'b0, n_q});

    always_comb begin
        state_d = state_q;
        ew_d    = ew_q;
        n_d     = n_q;
        cmax_d  = cmax_q;
        off_d   = off_q;
        bi_d    = bi_q;
        buf_d   = buf_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                ew_d   = ew_new;
                n_d    = n_new;
                cmax_d = chunks_m1(ew_new, LANE_WIDTH);
                buf_d  = vd_old;
                off_d  = '0;
                bi_d   = '0;
                if (vsew[2] && !instr_mask) err_d   = 1'b1;
                else if (n_new == '0)       state_d = ST_WB;
                else                        state_d = ST_RUN;
            end
            ST_RUN: begin
                buf_d = chain[NB_LANES];
                // Offset returns to 0 at every element start; lane carry chains depend on it.
                if (off_q == cmax_q) begin
                    off_d = '0;
                    bi_d  = bi_q + 17'(NB_LANES);
                    if (last) state_d = ST_WB;
                end else begin
                    off_d = off_q + 4'd1;
                end
            end
            ST_WB: if (wb.wb_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ew_q    <= '0;
            n_q     <= '0;
            cmax_q  <= '0;
            off_q   <= '0;
            bi_q    <= '0;
            buf_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ew_q    <= ew_d;
            n_q     <= n_d;
            cmax_q  <= cmax_d;
            off_q   <= off_d;
            bi_q    <= bi_d;
            buf_q   <= buf_d;
            err_q   <= err_d;
        end
    end

    assign busy              = (state_q != ST_IDLE);
    assign error             = err_q;
    assign alu_run           = (state_q == ST_RUN);
    assign alu_vsew          = alu_run ? ew_q : 3'd0;
    assign alu_byte_i        = bi_q;
    assign alu_in_reg_offset = off_q;
    assign wb.wb_valid       = (state_q == ST_WB);
    assign wb.wb_data        = buf_q;
endmodule
